// File: rtl/flight.sv
// -----------------------------------------------------------------------------
// flight -- minimal flight controller core.
//
// Receives RC frames on an inverted 8N1 serial line, mixes throttle/roll/
// pitch/yaw into four motor duties, drives four PWM outputs, cuts the motors
// after a silence timeout, and reports every accepted frame on a debug UART.
//
// Ports
//   CLK            system clock (BASE_FREQ Hz)
//   RST_N          asynchronous active-low reset
//   RX_IN          RC serial input, inverted polarity (idles low)
//   MOTOR_1..4     motor PWM outputs
//   IMU_SCLK/MOSI  IMU SPI clock/data, held low (bus reserved)
//   IMU_CS         IMU SPI chip select, held high (bus reserved)
//   IMU_MISO       IMU SPI data in, ignored
//   DEBUG_UART_TX  debug serial output, 8N1, idles high
//
// Internal handshakes are single-cycle valid pulses with no back-pressure:
// rx_valid qualifies rx_byte for exactly one clock; frame_ok marks the clock
// on which duty_1..4 hold the freshly accepted frame. A consumer that is not
// ready simply ignores the pulse (the debug transmitter drops the report).
// -----------------------------------------------------------------------------
module flight #(
   parameter int BASE_FREQ   = 10_000_000,
   parameter int RC_BAUD     = 115200,
   parameter int DEBUG_BAUD  = 400000,
   parameter int PWM_FREQ    = 1000,
   parameter int FAILSAFE_MS = 100
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic RX_IN,
   output logic MOTOR_1,
   output logic MOTOR_2,
   output logic MOTOR_3,
   output logic MOTOR_4,
   output logic IMU_SCLK,
   output logic IMU_MOSI,
   output logic IMU_CS,
   input  logic IMU_MISO,
   output logic DEBUG_UART_TX
);

   localparam int RC_CPB   = BASE_FREQ / RC_BAUD;
   localparam int DBG_CPB  = BASE_FREQ / DEBUG_BAUD;
   localparam int PWM_RAW  = BASE_FREQ / (PWM_FREQ * 256);
   localparam int PWM_DIV  = (PWM_RAW < 1) ? 1 : PWM_RAW;
   localparam int FS_LIMIT = FAILSAFE_MS * (BASE_FREQ / 1000);

   localparam int RC_W  = $clog2(RC_CPB + 1);
   localparam int DBG_W = $clog2(DBG_CPB + 1);
   localparam int PWM_W = $clog2(PWM_DIV + 1);
   localparam int FS_W  = $clog2(FS_LIMIT + 1);

   localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RC_CPB - 1);
   localparam logic [RC_W-1:0]  RC_HALF  = RC_W'((RC_CPB - 1) / 2);
   localparam logic [DBG_W-1:0] DBG_LAST = DBG_W'(DBG_CPB - 1);
   localparam logic [PWM_W-1:0] PWM_LAST = PWM_W'(PWM_DIV - 1);
   localparam logic [FS_W-1:0]  FS_MAX   = FS_W'(FS_LIMIT);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {P_IDLE, P_CH0, P_CH1, P_CH2, P_CH3, P_CHK} parse_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

   typedef struct packed {
      rx_state_t    rx;
      parse_state_t parse;
      tx_state_t    tx;
      logic         failsafe;
   } dbg_state_t;

   // ---------------- RC receiver ----------------
   // The synchronizer stores the already-inverted line, so it resets to the
   // idle level (1) of a conventional UART.
   logic            rx_meta, rx_sync;
   rx_state_t       rx_state;
   logic [RC_W-1:0] rx_cnt;
   logic [2:0]      rx_bit;
   logic [7:0]      rx_shift, rx_byte;
   logic            rx_valid;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= ~RX_IN;
         rx_sync <= rx_meta;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         rx_byte  <= '0;
         rx_valid <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               rx_cnt <= '0;
               rx_bit <= '0;
               if (!rx_sync) rx_state <= RX_START;
            end
            RX_START: begin
               // Re-check at half a bit so glitches do not start a byte.
               if (rx_cnt == RC_HALF) begin
                  rx_cnt   <= '0;
                  rx_state <= rx_sync ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt <= rx_cnt + RC_W'(1);
               end
            end
            RX_DATA: begin
               if (rx_cnt == RC_LAST) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rx_sync, rx_shift[7:1]};
                  if (rx_bit == 3'd7) rx_state <= RX_STOP;
                  else                rx_bit   <= rx_bit + 3'd1;
               end else begin
                  rx_cnt <= rx_cnt + RC_W'(1);
               end
            end
            RX_STOP: begin
               if (rx_cnt == RC_LAST) begin
                  rx_cnt   <= '0;
                  rx_state <= RX_IDLE;
                  if (rx_sync) begin
                     rx_byte  <= rx_shift;
                     rx_valid <= 1'b1;
                  end
               end else begin
                  rx_cnt <= rx_cnt + RC_W'(1);
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   // ---------------- Frame parser and mixer ----------------
   parse_state_t p_state;
   logic [7:0]   ch_t, ch_r, ch_p, ch_y;
   logic [7:0]   duty_1, duty_2, duty_3, duty_4;
   logic         frame_ok;

   logic [7:0]        ch_sum, chk_exp;
   logic signed [10:0] t_s, r_s, p_s, y_s;
   logic [7:0]        mix_1, mix_2, mix_3, mix_4;

   function automatic logic [7:0] mix_sat(input logic [7:0] thr,
                                          input logic signed [10:0] v);
      if (thr == 8'd0)          return 8'd0;
      else if (v < 11'sd0)      return 8'd0;
      else if (v > 11'sd255)    return 8'd255;
      else                      return v[7:0];
   endfunction

   assign ch_sum  = ch_t + ch_r + ch_p + ch_y;
   assign chk_exp = 8'hFF - ch_sum;
   assign t_s     = $signed({3'b000, ch_t});
   assign r_s     = $signed({3'b000, ch_r}) - 11'sd128;
   assign p_s     = $signed({3'b000, ch_p}) - 11'sd128;
   assign y_s     = $signed({3'b000, ch_y}) - 11'sd128;
   assign mix_1   = mix_sat(ch_t, t_s - r_s + p_s + y_s);
   assign mix_2   = mix_sat(ch_t, t_s - r_s - p_s - y_s);
   assign mix_3   = mix_sat(ch_t, t_s + r_s - p_s + y_s);
   assign mix_4   = mix_sat(ch_t, t_s + r_s + p_s - y_s);

   // Channel values are staging registers; only a good checksum commits them
   // into the duty registers, so a bad frame leaves the motors untouched.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         p_state  <= P_IDLE;
         ch_t     <= '0;
         ch_r     <= '0;
         ch_p     <= '0;
         ch_y     <= '0;
         duty_1   <= '0;
         duty_2   <= '0;
         duty_3   <= '0;
         duty_4   <= '0;
         frame_ok <= 1'b0;
      end else begin
         frame_ok <= 1'b0;
         if (rx_valid) begin
            case (p_state)
               P_IDLE: if (rx_byte == 8'h7E) p_state <= P_CH0;
               P_CH0: begin ch_t <= rx_byte; p_state <= P_CH1; end
               P_CH1: begin ch_r <= rx_byte; p_state <= P_CH2; end
               P_CH2: begin ch_p <= rx_byte; p_state <= P_CH3; end
               P_CH3: begin ch_y <= rx_byte; p_state <= P_CHK; end
               P_CHK: begin
                  p_state <= P_IDLE;
                  if (rx_byte == chk_exp) begin
                     frame_ok <= 1'b1;
                     duty_1   <= mix_1;
                     duty_2   <= mix_2;
                     duty_3   <= mix_3;
                     duty_4   <= mix_4;
                  end
               end
               default: p_state <= P_IDLE;
            endcase
         end
      end
   end

   // ---------------- Failsafe ----------------
   // Starts saturated so the motors stay off until the first good frame.
   logic [FS_W-1:0] fs_cnt;
   logic            failsafe;

   assign failsafe = (fs_cnt == FS_MAX);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)         fs_cnt <= FS_MAX;
      else if (frame_ok)  fs_cnt <= '0;
      else if (!failsafe) fs_cnt <= fs_cnt + FS_W'(1);
   end

   // ---------------- PWM ----------------
   // Active duties load only on the counter wrap, so a frame never glitches.
   logic [PWM_W-1:0] pre_cnt;
   logic [7:0]       pwm_cnt;
   logic [7:0]       act_1, act_2, act_3, act_4;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pre_cnt <= '0;
         pwm_cnt <= '0;
         act_1   <= '0;
         act_2   <= '0;
         act_3   <= '0;
         act_4   <= '0;
      end else if (pre_cnt == PWM_LAST) begin
         pre_cnt <= '0;
         pwm_cnt <= pwm_cnt + 8'd1;
         if (pwm_cnt == 8'hFF) begin
            act_1 <= failsafe ? 8'd0 : duty_1;
            act_2 <= failsafe ? 8'd0 : duty_2;
            act_3 <= failsafe ? 8'd0 : duty_3;
            act_4 <= failsafe ? 8'd0 : duty_4;
         end
      end else begin
         pre_cnt <= pre_cnt + PWM_W'(1);
      end
   end

   assign MOTOR_1 = (pwm_cnt < act_1);
   assign MOTOR_2 = (pwm_cnt < act_2);
   assign MOTOR_3 = (pwm_cnt < act_3);
   assign MOTOR_4 = (pwm_cnt < act_4);

   // ---------------- Debug transmitter ----------------
   // The five report bytes sit in one 40-bit register shifted one bit per
   // data bit, so after eight shifts the next byte is already at bit 0.
   tx_state_t        tx_state;
   logic [DBG_W-1:0] tx_cnt;
   logic [2:0]       tx_bit, tx_idx;
   logic [39:0]      tx_buf;
   logic             tx_out;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_idx   <= '0;
         tx_buf   <= '0;
         tx_out   <= 1'b1;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               tx_out <= 1'b1;
               if (frame_ok) begin
                  tx_buf   <= {duty_4, duty_3, duty_2, duty_1, 8'hA5};
                  tx_idx   <= '0;
                  tx_cnt   <= '0;
                  tx_out   <= 1'b0;
                  tx_state <= TX_START;
               end
            end
            TX_START: begin
               if (tx_cnt == DBG_LAST) begin
                  tx_cnt   <= '0;
                  tx_bit   <= '0;
                  tx_out   <= tx_buf[0];
                  tx_state <= TX_DATA;
               end else begin
                  tx_cnt <= tx_cnt + DBG_W'(1);
               end
            end
            TX_DATA: begin
               if (tx_cnt == DBG_LAST) begin
                  tx_cnt <= '0;
                  tx_buf <= {1'b0, tx_buf[39:1]};
                  if (tx_bit == 3'd7) begin
                     tx_out   <= 1'b1;
                     tx_state <= TX_STOP;
                  end else begin
                     tx_bit <= tx_bit + 3'd1;
                     tx_out <= tx_buf[1];
                  end
               end else begin
                  tx_cnt <= tx_cnt + DBG_W'(1);
               end
            end
            TX_STOP: begin
               if (tx_cnt == DBG_LAST) begin
                  tx_cnt <= '0;
                  if (tx_idx == 3'd4) begin
                     tx_state <= TX_IDLE;
                  end else begin
                     tx_idx   <= tx_idx + 3'd1;
                     tx_out   <= 1'b0;
                     tx_state <= TX_START;
                  end
               end else begin
                  tx_cnt <= tx_cnt + DBG_W'(1);
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   assign DEBUG_UART_TX = tx_out;

   // ---------------- IMU bus (reserved) and state visibility ----------------
   assign IMU_CS   = 1'b1;
   assign IMU_SCLK = 1'b0;
   assign IMU_MOSI = 1'b0;

   dbg_state_t dbg_state;
   assign dbg_state = '{rx: rx_state, parse: p_state, tx: tx_state, failsafe: failsafe};

   logic unused_sinks;
   assign unused_sinks = ^{IMU_MISO, dbg_state};

endmodule

// File: tb/tb_flight.sv
// -----------------------------------------------------------------------------
// tb_flight -- self-checking bench for flight.
// Scaled clock/baud parameters keep every frame, report and the failsafe
// timeout short. Duties are measured as high-cycle counts over one full
// 256-step PWM frame; debug bytes are decoded from DEBUG_UART_TX.
// -----------------------------------------------------------------------------
module tb_flight;

   localparam int BASE_FREQ   = 1_000_000;
   localparam int RC_BAUD     = 125_000;   // 8 clocks per bit
   localparam int DEBUG_BAUD  = 50_000;    // 20 clocks per bit
   localparam int PWM_FREQ    = 2000;      // one PWM step per clock
   localparam int FAILSAFE_MS = 10;        // 10000 clocks
   localparam int RC_CPB      = BASE_FREQ / RC_BAUD;
   localparam int DBG_CPB     = BASE_FREQ / DEBUG_BAUD;
   localparam int FS_CLKS     = FAILSAFE_MS * (BASE_FREQ / 1000);
   localparam int SETTLE      = 1060;      // report (1000 clocks) plus margin

   // ---------------- clock / reset ----------------
   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   logic RX_IN = 1'b0;
   logic IMU_MISO = 1'b0;
   logic MOTOR_1, MOTOR_2, MOTOR_3, MOTOR_4;
   logic IMU_SCLK, IMU_MOSI, IMU_CS;
   logic DEBUG_UART_TX;

   always #5 CLK = ~CLK;

   flight #(
      .BASE_FREQ(BASE_FREQ), .RC_BAUD(RC_BAUD), .DEBUG_BAUD(DEBUG_BAUD),
      .PWM_FREQ(PWM_FREQ), .FAILSAFE_MS(FAILSAFE_MS)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .RX_IN(RX_IN),
      .MOTOR_1(MOTOR_1), .MOTOR_2(MOTOR_2), .MOTOR_3(MOTOR_3), .MOTOR_4(MOTOR_4),
      .IMU_SCLK(IMU_SCLK), .IMU_MOSI(IMU_MOSI), .IMU_CS(IMU_CS), .IMU_MISO(IMU_MISO),
      .DEBUG_UART_TX(DEBUG_UART_TX)
   );

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   int meas[4];
   int model_duty[4];
   bit model_fs = 1'b1;

   task automatic check(input string name, input integer act, input integer exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int model_mix(input int t, input int r, input int p,
                                    input int y, input int n);
      int sr, sp, sy, v;
      case (n)
         0:       begin sr = -1; sp =  1; sy =  1; end
         1:       begin sr = -1; sp = -1; sy = -1; end
         2:       begin sr =  1; sp = -1; sy =  1; end
         default: begin sr =  1; sp =  1; sy = -1; end
      endcase
      v = t + sr * (r - 128) + sp * (p - 128) + sy * (y - 128);
      if (t == 0) return 0;
      if (v < 0) return 0;
      if (v > 255) return 255;
      return v;
   endfunction

   function automatic int good_chk(input int t, input int r, input int p, input int y);
      return 255 - ((t + r + p + y) % 256);
   endfunction

   task automatic model_frame(input int t, input int r, input int p, input int y,
                              input int chk, input bit report);
      if ((t + r + p + y + chk) % 256 == 255) begin
         model_fs = 1'b0;
         for (int n = 0; n < 4; n++) model_duty[n] = model_mix(t, r, p, y, n);
         if (report) begin
            exp_q.push_back(8'hA5);
            for (int n = 0; n < 4; n++) exp_q.push_back(8'(model_duty[n]));
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic send_bit(input logic b);
      RX_IN = ~b;  // line is inverted
      repeat (RC_CPB) @(negedge CLK);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop_ok);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stop_ok);
      RX_IN = 1'b0;
      if (!stop_ok) repeat (2 * RC_CPB) @(negedge CLK);
   endtask

   task automatic send_frame(input int t, input int r, input int p, input int y, input int chk);
      send_byte(8'h7E, 1'b1);
      send_byte(8'(t), 1'b1);
      send_byte(8'(r), 1'b1);
      send_byte(8'(p), 1'b1);
      send_byte(8'(y), 1'b1);
      send_byte(8'(chk), 1'b1);
   endtask

   task automatic measure_duty();
      for (int k = 0; k < 4; k++) meas[k] = 0;
      repeat (256) begin
         @(negedge CLK);
         meas[0] += int'(MOTOR_1);
         meas[1] += int'(MOTOR_2);
         meas[2] += int'(MOTOR_3);
         meas[3] += int'(MOTOR_4);
      end
   endtask

   task automatic check_duties(input string tag, input int e0, input int e1,
                               input int e2, input int e3);
      measure_duty();
      check({tag, " M1"}, meas[0], e0);
      check({tag, " M2"}, meas[1], e1);
      check({tag, " M3"}, meas[2], e2);
      check({tag, " M4"}, meas[3], e3);
   endtask

   task automatic check_model_duties(input string tag);
      if (model_fs) check_duties(tag, 0, 0, 0, 0);
      else check_duties(tag, model_duty[0], model_duty[1], model_duty[2], model_duty[3]);
   endtask

   task automatic check_report(input string tag);
      int n;
      logic [7:0] e;
      n = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (got_q.size() == 0) check($sformatf("%s report byte %0d missing", tag, n), 999, e);
         else check($sformatf("%s report byte %0d", tag, n), got_q.pop_front(), e);
         n++;
      end
      check({tag, " extra report bytes"}, got_q.size(), 0);
      got_q.delete();
   endtask

   task automatic run_frame(input string tag, input int t, input int r, input int p,
                            input int y, input int chk);
      send_frame(t, r, p, y, chk);
      model_frame(t, r, p, y, chk, 1'b1);
      repeat (SETTLE) @(negedge CLK);
      check_model_duties(tag);
      check_report(tag);
   endtask

   // ---------------- debug UART monitor ----------------
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge CLK);
         if (RST_N && DEBUG_UART_TX == 1'b0) begin
            repeat (DBG_CPB / 2) @(negedge CLK);
            if (DEBUG_UART_TX == 1'b0) begin
               for (int i = 0; i < 8; i++) begin
                  repeat (DBG_CPB) @(negedge CLK);
                  b[i] = DEBUG_UART_TX;
               end
               repeat (DBG_CPB) @(negedge CLK);
               check("debug stop bit", DEBUG_UART_TX, 1);
               got_q.push_back(b);
            end
         end
      end
   end

   // ---------------- vector table ----------------
   typedef struct {
      logic [7:0] t, r, p, y, chk;
      logic [7:0] e1, e2, e3, e4;
      bit         report;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int t, r, p, y, chk;
      bit prev_bad;

      // t, r, p, y, chk, expected M1..M4, report expected
      vecs[0] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'hFF, 8'h80, 8'h80, 8'h80, 8'h80, 1'b1};
      vecs[1] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h80, 8'h80, 8'h80, 8'h80, 1'b0};
      vecs[2] = '{8'h80, 8'h90, 8'h80, 8'h80, 8'hEF, 8'h70, 8'h70, 8'h90, 8'h90, 1'b1};
      // Checksum byte follows the 0xFF - sum rule: F0+FF+80+80 = 0xEF mod 256.
      vecs[3] = '{8'hF0, 8'hFF, 8'h80, 8'h80, 8'h10, 8'h71, 8'h71, 8'hFF, 8'hFF, 1'b1};
      vecs[4] = '{8'h00, 8'h00, 8'h80, 8'h80, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1};
      vecs[5] = '{8'h7E, 8'h7E, 8'h7E, 8'h7E, 8'h07, 8'h7C, 8'h84, 8'h7C, 8'h7C, 1'b1};
      vecs[6] = '{8'h0A, 8'hFF, 8'h00, 8'h00, 8'hF6, 8'h00, 8'h8B, 8'h89, 8'h89, 1'b1};

      for (int n = 0; n < 4; n++) model_duty[n] = 0;

      // Reset state
      repeat (3) @(negedge CLK);
      check("reset MOTOR_1", MOTOR_1, 0);
      check("reset MOTOR_2", MOTOR_2, 0);
      check("reset MOTOR_3", MOTOR_3, 0);
      check("reset MOTOR_4", MOTOR_4, 0);
      check("reset DEBUG_UART_TX", DEBUG_UART_TX, 1);
      check("IMU_CS", IMU_CS, 1);
      check("IMU_SCLK", IMU_SCLK, 0);
      check("IMU_MOSI", IMU_MOSI, 0);
      RST_N = 1'b1;
      repeat (20) @(negedge CLK);
      check_duties("post-reset idle", 0, 0, 0, 0);

      // Table-driven vectors
      for (int i = 0; i < 7; i++) begin
         send_frame(vecs[i].t, vecs[i].r, vecs[i].p, vecs[i].y, vecs[i].chk);
         model_frame(vecs[i].t, vecs[i].r, vecs[i].p, vecs[i].y, vecs[i].chk, 1'b0);
         if (vecs[i].report) begin
            exp_q.push_back(8'hA5);
            exp_q.push_back(vecs[i].e1);
            exp_q.push_back(vecs[i].e2);
            exp_q.push_back(vecs[i].e3);
            exp_q.push_back(vecs[i].e4);
         end
         repeat (SETTLE) @(negedge CLK);
         check_duties($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2, vecs[i].e3, vecs[i].e4);
         check_report($sformatf("vec%0d", i));
      end

      // Byte with a bad stop bit is discarded, so the frame around it still decodes.
      send_byte(8'h7E, 1'b1);
      send_byte(8'h10, 1'b0);
      send_frame_tail: begin
         send_byte(8'h80, 1'b1);
         send_byte(8'h80, 1'b1);
         send_byte(8'h80, 1'b1);
         send_byte(8'h80, 1'b1);
         send_byte(8'hFF, 1'b1);
      end
      model_frame(8'h80, 8'h80, 8'h80, 8'h80, 8'hFF, 1'b1);
      repeat (SETTLE) @(negedge CLK);
      check_model_duties("bad stop");
      check_report("bad stop");

      // Second frame arrives while the first report is still going out.
      send_frame(8'hA0, 8'h60, 8'h90, 8'h88, good_chk(8'hA0, 8'h60, 8'h90, 8'h88));
      model_frame(8'hA0, 8'h60, 8'h90, 8'h88, good_chk(8'hA0, 8'h60, 8'h90, 8'h88), 1'b1);
      send_frame(8'h50, 8'h84, 8'h7A, 8'h80, good_chk(8'h50, 8'h84, 8'h7A, 8'h80));
      model_frame(8'h50, 8'h84, 8'h7A, 8'h80, good_chk(8'h50, 8'h84, 8'h7A, 8'h80), 1'b0);
      repeat (SETTLE) @(negedge CLK);
      check_model_duties("busy drop");
      check_report("busy drop");

      // Failsafe after silence, then recovery.
      run_frame("pre-failsafe", 8'h80, 8'h80, 8'h80, 8'h80, 8'hFF);
      repeat (FS_CLKS + 300) @(negedge CLK);
      model_fs = 1'b1;
      check_model_duties("failsafe");
      run_frame("failsafe recover", 8'h90, 8'h88, 8'h78, 8'h80, good_chk(8'h90, 8'h88, 8'h78, 8'h80));

      // Reset while the parser is collecting pitch.
      send_byte(8'h7E, 1'b1);
      send_byte(8'h80, 1'b1);
      send_byte(8'h90, 1'b1);
      RST_N = 1'b0;
      #1;
      check("mid-frame reset MOTOR_1", MOTOR_1, 0);
      check("mid-frame reset MOTOR_2", MOTOR_2, 0);
      check("mid-frame reset MOTOR_3", MOTOR_3, 0);
      check("mid-frame reset MOTOR_4", MOTOR_4, 0);
      check("mid-frame reset DEBUG_UART_TX", DEBUG_UART_TX, 1);
      repeat (5) @(negedge CLK);
      RST_N = 1'b1;
      for (int n = 0; n < 4; n++) model_duty[n] = 0;
      model_fs = 1'b1;
      repeat (20) @(negedge CLK);
      check_duties("after mid-frame reset", 0, 0, 0, 0);
      run_frame("post-reset frame", 8'h80, 8'h90, 8'h80, 8'h80, 8'hEF);

      // Randomized frames against the model; never two bad checksums in a row.
      prev_bad = 1'b0;
      for (int i = 0; i < 12; i++) begin
         t = $urandom_range(0, 255);
         if ($urandom_range(0, 5) == 0) t = 0;
         r = $urandom_range(0, 255);
         p = $urandom_range(0, 255);
         y = $urandom_range(0, 255);
         if ($urandom_range(0, 7) == 0) r = 8'h7E;
         chk = good_chk(t, r, p, y);
         if (!prev_bad && $urandom_range(0, 3) == 0) begin
            chk = (chk + $urandom_range(1, 255)) % 256;
            prev_bad = 1'b1;
         end else begin
            prev_bad = 1'b0;
         end
         run_frame($sformatf("rand%0d", i), t, r, p, y, chk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
